// File: rtl/rics_pkg.sv
// Shared definitions for the fetch/decode slice: fetch state encoding,
// opcode field placement and default datapath widths.
package rics_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;

    // Opcode lives in the top three bits of the instruction word.
    localparam int OPC_W   = 3;
    localparam int OPC_MSB = DEF_INSTR_W - 1;
    localparam int OPC_LSB = DEF_INSTR_W - OPC_W;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request bus, the decode handshake and
// the branch redirect into one interface. The fetch unit is the master.
interface instr_fetch_unit_if
    import rics_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic               inp_enable;
    logic               out_imemReq;
    logic [ADDR_W-1:0]  out_imemAddr;
    logic               inp_imemGnt;
    logic               inp_imemValid;
    logic [INSTR_W-1:0] inp_imemData;
    logic               out_instrValid;
    logic [INSTR_W-1:0] out_instr;
    logic [OPC_W-1:0]   out_opCode;
    logic [ADDR_W-1:0]  out_pc;
    logic               inp_decReady;
    logic               inp_redirect;
    logic [ADDR_W-1:0]  inp_redirectPc;
    logic               out_protoErr;

    modport master (
        input  inp_enable, inp_imemGnt, inp_imemValid, inp_imemData,
               inp_decReady, inp_redirect, inp_redirectPc,
        output out_imemReq, out_imemAddr, out_instrValid, out_instr,
               out_opCode, out_pc, out_protoErr
    );

    modport slave (
        output inp_enable, inp_imemGnt, inp_imemValid, inp_imemData,
               inp_decReady, inp_redirect, inp_redirectPc,
        input  out_imemReq, out_imemAddr, out_instrValid, out_instr,
               out_opCode, out_pc, out_protoErr
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: a redirect load wins over everything,
// otherwise the PC advances by one (wrapping) unless held.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next PC: redirect target first, then increment, otherwise keep.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc;
        end else if (!hold) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register, returns to the reset vector on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps one request outstanding to instruction
// memory, holds the returned word for decode, and follows branch redirects.
// A redirect that races an outstanding request marks the response for
// discard so the stale word never reaches decode.
module instr_fetch_unit
    import rics_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               inp_clk,
    input  logic               inp_rst_n,
    instr_fetch_unit_if.master bus
);

    fetch_state_e       state_d, state_q;
    logic               discard_d, discard_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  held_pc_d, held_pc_q;
    logic               proto_err_d, proto_err_q;
    logic               pc_hold;
    logic [ADDR_W-1:0]  pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (inp_clk),
        .rst_n   (inp_rst_n),
        .load_en (bus.inp_redirect),
        .load_pc (bus.inp_redirectPc),
        .hold    (pc_hold),
        .pc      (pc)
    );

    // Next-state logic: redirect overrides normal sequencing in every state.
    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        instr_d     = instr_q;
        held_pc_d   = held_pc_q;
        proto_err_d = proto_err_q;
        pc_hold     = 1'b1;

        if (bus.inp_imemValid && (state_q != FETCH_WAIT)) begin
            proto_err_d = 1'b1;
        end

        if (bus.inp_redirect) begin
            case (state_q)
                FETCH_IDLE: state_d = FETCH_IDLE;
                FETCH_REQ: begin
                    if (bus.inp_imemGnt) begin
                        state_d   = FETCH_WAIT;
                        discard_d = 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.inp_imemValid) begin
                        state_d   = FETCH_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                FETCH_HOLD: state_d = FETCH_REQ;
                default:    state_d = FETCH_IDLE;
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (bus.inp_enable) begin
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (bus.inp_imemGnt) begin
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.inp_imemValid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = FETCH_REQ;
                        end else begin
                            instr_d   = bus.inp_imemData;
                            held_pc_d = pc;
                            pc_hold   = 1'b0;
                            state_d   = FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (bus.inp_decReady) begin
                        state_d = bus.inp_enable ? FETCH_REQ : FETCH_IDLE;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    // State, held instruction and sticky error registers.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_q     <= FETCH_IDLE;
            discard_q   <= 1'b0;
            instr_q     <= '0;
            held_pc_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            instr_q     <= instr_d;
            held_pc_q   <= held_pc_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.out_imemReq    = (state_q == FETCH_REQ);
    assign bus.out_imemAddr   = pc;
    assign bus.out_instrValid = (state_q == FETCH_HOLD);
    assign bus.out_instr      = instr_q;
    assign bus.out_opCode     = instr_q[INSTR_W-1 -: OPC_W];
    assign bus.out_pc         = held_pc_q;
    assign bus.out_protoErr   = proto_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model,
// plus directed scenarios for fetch, backpressure, redirect, wrap, error
// and asynchronous reset.
module tb_instr_fetch_unit;
    import rics_pkg::*;

    localparam int AW = 16;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Clock generation, 10 time-unit period.
    always #5 clk = ~clk;

    logic          en, gnt, vld, rdy, redir;
    logic [IW-1:0] data;
    logic [AW-1:0] rpc;

    int vector_count = 0;
    int miscompare_count = 0;

    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) wbus ();

    assign bus.inp_enable      = en;
    assign bus.inp_imemGnt     = gnt;
    assign bus.inp_imemValid   = vld;
    assign bus.inp_imemData    = data;
    assign bus.inp_decReady    = rdy;
    assign bus.inp_redirect    = redir;
    assign bus.inp_redirectPc  = rpc;
    assign wbus.inp_enable     = en;
    assign wbus.inp_imemGnt    = gnt;
    assign wbus.inp_imemValid  = vld;
    assign wbus.inp_imemData   = data;
    assign wbus.inp_decReady   = rdy;
    assign wbus.inp_redirect   = redir;
    assign wbus.inp_redirectPc = rpc;

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
        .inp_clk   (clk),
        .inp_rst_n (rst_n),
        .bus       (bus)
    );

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'hFFFF)) dut_wrap (
        .inp_clk   (clk),
        .inp_rst_n (rst_n),
        .bus       (wbus)
    );

    // Reference model: what the unit is doing, in transaction terms.
    logic          m_req, m_out, m_sq, m_hold, m_err;
    logic [AW-1:0] m_pc, m_hpc;
    logic [IW-1:0] m_instr;

    task automatic modelReset();
        m_req = 1'b0; m_out = 1'b0; m_sq = 1'b0; m_hold = 1'b0; m_err = 1'b0;
        m_pc = 16'h0000; m_hpc = 16'h0000; m_instr = 16'h0000;
    endtask

    task automatic modelStep();
        logic idle_now;
        idle_now = !m_req && !m_out && !m_hold;
        if (vld && !m_out) m_err = 1'b1;
        if (redir) begin
            if (m_req) begin
                if (gnt) begin m_req = 1'b0; m_out = 1'b1; m_sq = 1'b1; end
            end else if (m_out) begin
                if (vld) begin m_out = 1'b0; m_sq = 1'b0; m_req = 1'b1; end
                else m_sq = 1'b1;
            end else if (m_hold) begin
                m_hold = 1'b0; m_req = 1'b1;
            end
            m_pc = rpc;
        end else if (idle_now) begin
            if (en) m_req = 1'b1;
        end else if (m_req) begin
            if (gnt) begin m_req = 1'b0; m_out = 1'b1; end
        end else if (m_out) begin
            if (vld) begin
                m_out = 1'b0;
                if (m_sq) begin
                    m_sq = 1'b0; m_req = 1'b1;
                end else begin
                    m_hold = 1'b1; m_instr = data; m_hpc = m_pc; m_pc = m_pc + 16'd1;
                end
            end
        end else if (m_hold && rdy) begin
            m_hold = 1'b0; m_req = en;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        logic [IW-1:0] mi;
        mi = m_instr;
        checkOutput("imemReq",    32'(bus.out_imemReq),    32'(m_req));
        checkOutput("imemAddr",   32'(bus.out_imemAddr),   32'(m_pc));
        checkOutput("instrValid", 32'(bus.out_instrValid), 32'(m_hold));
        checkOutput("instr",      32'(bus.out_instr),      32'(m_instr));
        checkOutput("opCode",     32'(bus.out_opCode),     32'(mi[IW-1 -: 3]));
        checkOutput("pc",         32'(bus.out_pc),         32'(m_hpc));
        checkOutput("protoErr",   32'(bus.out_protoErr),   32'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic applyStimulus(input logic e, input logic g, input logic v,
                                 input logic [IW-1:0] d, input logic r,
                                 input logic rd, input logic [AW-1:0] rp);
        en = e; gnt = g; vld = v; data = d; rdy = r; redir = rd; rpc = rp;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        en = 0; gnt = 0; vld = 0; data = '0; rdy = 0; redir = 0; rpc = '0;
        modelReset();
        #12;
        $display("[TB] reset state");
        checkAll();
        checkOutput("wrapResetAddr", 32'(wbus.out_imemAddr), 32'h0000FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic fetch");
        applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'hA123, 0, 0, 16'h0000);
        checkOutput("basicValid",  32'(bus.out_instrValid), 32'd1);
        checkOutput("basicInstr",  32'(bus.out_instr),      32'h0000A123);
        checkOutput("basicOpCode", 32'(bus.out_opCode),     32'd5);
        checkOutput("basicPc",     32'(bus.out_pc),         32'd0);
        checkOutput("wrapPc",      32'(wbus.out_pc),        32'h0000FFFF);
        applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("basicNextAddr", 32'(bus.out_imemAddr),  32'd1);
        checkOutput("basicNextReq",  32'(bus.out_imemReq),   32'd1);
        checkOutput("wrapNextAddr",  32'(wbus.out_imemAddr), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'h5A5A, 0, 0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
            checkOutput("bpInstr", 32'(bus.out_instr),      32'h00005A5A);
            checkOutput("bpPc",    32'(bus.out_pc),         32'd1);
            checkOutput("bpValid", 32'(bus.out_instrValid), 32'd1);
            checkOutput("bpReq",   32'(bus.out_imemReq),    32'd0);
        end
        applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("bpReleaseReq", 32'(bus.out_imemReq), 32'd1);

        $display("[TB] redirect while waiting");
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0000, 0, 1, 16'h0040);
        applyStimulus(1, 0, 1, 16'hFFFF, 0, 0, 16'h0000);
        checkOutput("redirNoValid", 32'(bus.out_instrValid), 32'd0);
        checkOutput("redirAddr",    32'(bus.out_imemAddr),   32'h00000040);
        checkOutput("redirReq",     32'(bus.out_imemReq),    32'd1);

        $display("[TB] protocol error");
        applyStimulus(0, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(0, 0, 1, 16'h1234, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
        applyStimulus(0, 0, 1, 16'hBEEF, 0, 0, 16'h0000);
        checkOutput("protoErrSet", 32'(bus.out_protoErr), 32'd1);
        applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'h2222, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("protoErrSticky", 32'(bus.out_protoErr), 32'd1);

        $display("[TB] reset during wait");
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstReq",      32'(bus.out_imemReq),    32'd0);
        checkOutput("rstAddr",     32'(bus.out_imemAddr),   32'd0);
        checkOutput("rstValid",    32'(bus.out_instrValid), 32'd0);
        checkOutput("rstInstr",    32'(bus.out_instr),      32'd0);
        checkOutput("rstPc",       32'(bus.out_pc),         32'd0);
        checkOutput("rstProtoErr", 32'(bus.out_protoErr),   32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("restartAddr", 32'(bus.out_imemAddr), 32'd0);
        applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'h7001, 0, 0, 16'h0000);
        checkOutput("restartPc", 32'(bus.out_pc), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            logic e, g, v, r, rd;
            logic [IW-1:0] d;
            logic [AW-1:0] rp;
            e  = ($urandom_range(0, 99) < 85);
            g  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            v  = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 8);
            d  = 16'($urandom());
            rp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
            applyStimulus(e, g, v, d, r, rd, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
